prach_reshape_sched: RTL and testbench

PRACH_RESHAPE_SCHED -- requirements
Module: prach_reshape_sched

---
 rtl/prach_reshape_sched_pkg.sv | 25 ++
 rtl/prach_reshape_sched_if.sv | 19 +
 rtl/prach_rr_arb.sv | 35 +++
 rtl/prach_reshape_sched.sv | 137 +++++++++++++
 tb/tb_prach_reshape_sched.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/prach_reshape_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prach_pkg
// Description : Shared defaults, state encoding and sample-pair type for the
//               PRACH reshape scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package prach_pkg;

    localparam int NCH_DEF  = 8;
    localparam int SIZE_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } prach_state_e;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
    } sample_t;

endpackage
`default_nettype wire

// File: rtl/prach_reshape_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : prach_reshape_sched_if
// Description : Output sample stream from the scheduler to the reshape path.
// Revision    : 1.0 - initial release
// ============================================================================
interface prach_reshape_sched_if;
    import prach_pkg::*;

    sample_t     dout_dq;
    logic        dout_dv;
    logic [7:0]  dout_chn;
    logic        sync_out;

    modport master (output dout_dq, output dout_dv, output dout_chn, output sync_out);
    modport slave  (input  dout_dq, input  dout_dv, input  dout_chn, input  sync_out);

endinterface
`default_nettype wire

// File: rtl/prach_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : prach_rr_arb
// Description : Combinational round-robin pick of the first request at or
//               after ptr, wrapping modulo NCH.
// Revision    : 1.0 - initial release
// ============================================================================
module prach_rr_arb #(
    parameter int NCH = 8,
    parameter int IW  = 3
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [IW-1:0]  gnt_idx,
    output logic           gnt_vld
);

    logic [IW-1:0] w_sel;

    // Walk from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        w_sel   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_sel = IW'((int'(ptr) + k) % NCH);
            if (req[w_sel]) begin
                gnt_idx = w_sel;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/prach_reshape_sched.sv
`default_nettype none
// ============================================================================
// Module      : prach_reshape_sched
// Description : Round-robin burst scheduler feeding fixed-size sample bursts
//               with inter-burst gaps and frame-sync marking.
// Revision    : 1.0 - initial release
// ============================================================================
module prach_reshape_sched
    import prach_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int SIZE = SIZE_DEF,
    parameter int GAP  = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic [NCH-1:0]         ch_en,
    input  wire logic [NCH-1:0]         ch_avail,
    output logic      [NCH-1:0]         ch_rd,
    input  wire sample_t [NCH-1:0]      ch_dq,
    input  wire logic                   sync_in,
    prach_reshape_sched_if.master       dout_if,
    output logic                        err_udf
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW = $clog2(SIZE);

    localparam logic [1:0]    C_IDLE      = ST_IDLE;
    localparam logic [1:0]    C_BURST     = ST_BURST;
    localparam logic [1:0]    C_GAP       = ST_GAP;
    localparam logic [BW-1:0] C_BEAT_LAST = BW'(SIZE - 1);
    localparam logic [3:0]    C_GAP_LAST  = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
    localparam logic [IW-1:0] C_CH_LAST   = IW'(NCH - 1);

    logic [1:0]    r_state;
    logic [IW-1:0] r_grant;
    logic [IW-1:0] r_ptr;
    logic [BW-1:0] r_beat;
    logic [3:0]    r_gap;
    logic          r_armed;
    logic          r_sync_pend;
    logic          r_burst_sync;
    logic          r_p1_dv;
    logic          r_p1_sync;
    logic [IW-1:0] r_p1_chn;

    logic [IW-1:0] w_ptr;
    logic [IW-1:0] w_gnt_idx;
    logic          w_gnt_vld;
    logic          w_beat_last;
    logic          w_gap_last;
    logic          w_arb_slot;
    logic          w_start;

    assign w_ptr       = sync_in ? '0 : r_ptr;
    assign w_beat_last = (r_state == C_BURST) && (r_beat == C_BEAT_LAST);
    assign w_gap_last  = (r_state == C_GAP) && (r_gap == C_GAP_LAST);
    // The last gap cycle (or last beat with no gap) doubles as the arbitration
    // slot so bursts repeat every SIZE+GAP cycles under continuous demand.
    assign w_arb_slot  = (r_state == C_IDLE) || w_gap_last || (w_beat_last && (GAP == 0));
    assign w_start     = r_armed && w_arb_slot && w_gnt_vld;
    assign ch_rd       = (r_state == C_BURST) ? (NCH'(1) << r_grant) : '0;

    prach_rr_arb #(
        .NCH (NCH),
        .IW  (IW)
    ) u_arb (
        .req     (ch_avail & ch_en),
        .ptr     (w_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_vld (w_gnt_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= C_IDLE;
            r_grant      <= '0;
            r_ptr        <= '0;
            r_beat       <= '0;
            r_gap        <= '0;
            r_armed      <= 1'b0;
            r_sync_pend  <= 1'b0;
            r_burst_sync <= 1'b0;
            err_udf      <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_beat  <= (r_state == C_BURST) ? r_beat + 1'b1 : '0;
            r_gap   <= ((r_state == C_GAP) && !w_gap_last) ? r_gap + 1'b1 : '0;
            if ((r_state == C_BURST) && !ch_avail[r_grant])
                err_udf <= 1'b1;
            if (w_start) begin
                r_state      <= C_BURST;
                r_grant      <= w_gnt_idx;
                r_ptr        <= (w_gnt_idx == C_CH_LAST) ? '0 : w_gnt_idx + 1'b1;
                r_burst_sync <= r_sync_pend | sync_in;
                r_sync_pend  <= 1'b0;
            end else begin
                if (sync_in) begin
                    r_sync_pend <= 1'b1;
                    r_ptr       <= '0;
                end
                case (r_state)
                    C_IDLE:  r_state <= C_IDLE;
                    C_BURST: if (w_beat_last) r_state <= (GAP == 0) ? C_IDLE : C_GAP;
                    C_GAP:   if (w_gap_last) r_state <= C_IDLE;
                    default: r_state <= C_IDLE;
                endcase
            end
        end
    end

    // Two-stage output: capture read-side info, then the sample returned a cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_dv          <= 1'b0;
            r_p1_sync        <= 1'b0;
            r_p1_chn         <= '0;
            dout_if.dout_dq  <= '0;
            dout_if.dout_dv  <= 1'b0;
            dout_if.dout_chn <= '0;
            dout_if.sync_out <= 1'b0;
        end else begin
            r_p1_dv          <= (r_state == C_BURST);
            r_p1_sync        <= (r_state == C_BURST) && (r_beat == '0) && r_burst_sync;
            r_p1_chn         <= r_grant;
            dout_if.dout_dv  <= r_p1_dv;
            dout_if.sync_out <= r_p1_sync;
            if (r_p1_dv) begin
                dout_if.dout_dq  <= ch_dq[r_p1_chn];
                dout_if.dout_chn <= 8'(r_p1_chn);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prach_reshape_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_prach_reshape_sched
// Description : Randomized bench with a burst-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prach_reshape_sched;
    import prach_pkg::*;

    localparam int NCH  = 8;
    localparam int SIZE = 64;
    localparam int GAP  = 2;
    localparam int MAXC = 6000;

    logic                clk      = 1'b0;
    logic                rst_n    = 1'b0;
    logic [NCH-1:0]      ch_en    = '0;
    logic [NCH-1:0]      ch_avail = '0;
    logic [NCH-1:0]      ch_rd;
    sample_t [NCH-1:0]   ch_dq    = '0;
    logic                sync_in  = 1'b0;
    logic                err_udf;

    prach_reshape_sched_if dif();

    prach_reshape_sched #(
        .NCH  (NCH),
        .SIZE (SIZE),
        .GAP  (GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_en    (ch_en),
        .ch_avail (ch_avail),
        .ch_rd    (ch_rd),
        .ch_dq    (ch_dq),
        .sync_in  (sync_in),
        .dout_if  (dif),
        .err_udf  (err_udf)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Expected outputs indexed by the negedge at which they are observed.
    bit [NCH-1:0] e_rd  [MAXC];
    bit           e_dv  [MAXC];
    bit           e_sy  [MAXC];
    bit [7:0]     e_chn [MAXC];
    bit [31:0]    dq_hist [MAXC][NCH];

    int        m_ptr    = 0;
    bit        m_pend   = 0;
    bit        m_err    = 0;
    int        m_free   = 1 << 30;
    int        m_bstart = -1;
    int        m_g      = 0;
    bit [31:0] m_dq     = 0;
    bit        m_rst_prev = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h want %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_pend = 0; m_err = 0; m_bstart = -1; m_dq = 0; m_free = 1 << 30;
        for (int i = cyc + 1; i < MAXC; i++) begin
            e_rd[i] = '0; e_dv[i] = 0; e_sy[i] = 0; e_chn[i] = '0;
        end
    endtask

    // Behaviour of one rising edge n given the inputs sampled there.
    task automatic model_edge(input int n, input bit [NCH-1:0] en, input bit [NCH-1:0] av, input bit sy);
        bit started;
        int g, p, c;
        started = 0; g = 0;
        if (m_bstart >= 0 && n > m_bstart && n <= m_bstart + SIZE && !av[m_g])
            m_err = 1;
        if (n >= m_free) begin
            p = sy ? 0 : m_ptr;
            for (int k = 0; k < NCH; k++) begin
                c = (p + k) % NCH;
                if (!started && en[c] && av[c]) begin
                    started = 1; g = c;
                end
            end
        end
        if (started) begin
            m_g = g; m_bstart = n; m_free = n + SIZE + GAP; m_ptr = (g + 1) % NCH;
            for (int i = 1; i <= SIZE; i++)
                if (n + i < MAXC) begin
                    e_rd[n + i] = '0;
                    e_rd[n + i][g] = 1'b1;
                end
            for (int i = 3; i <= SIZE + 2; i++)
                if (n + i < MAXC) begin
                    e_dv[n + i] = 1; e_chn[n + i] = 8'(g);
                end
            if (n + 3 < MAXC) e_sy[n + 3] = m_pend | sy;
            m_pend = 0;
        end else if (sy) begin
            m_pend = 1; m_ptr = 0;
        end
    endtask

    task automatic check_outputs();
        check_val("ch_rd", ch_rd, e_rd[cyc]);
        check_val("dout_dv", dif.dout_dv, e_dv[cyc]);
        check_val("sync_out", dif.sync_out, e_sy[cyc]);
        check_val("err_udf", err_udf, m_err);
        if (e_dv[cyc]) begin
            m_dq = dq_hist[cyc - 1][e_chn[cyc]];
            check_val("dout_chn", dif.dout_chn, e_chn[cyc]);
        end
        check_val("dout_dq", dif.dout_dq, m_dq);
    endtask

    task automatic step(input bit [NCH-1:0] en, input bit [NCH-1:0] av, input bit sy, input bit rst_v);
        @(negedge clk);
        cyc++;
        check_outputs();
        if (!rst_v) model_reset();
        else if (!m_rst_prev) m_free = cyc + 1;
        m_rst_prev = rst_v;
        rst_n    = rst_v;
        ch_en    = en;
        ch_avail = av;
        sync_in  = sy & rst_v;
        for (int k = 0; k < NCH; k++) begin
            dq_hist[cyc][k] = $urandom;
            ch_dq[k] = dq_hist[cyc][k];
        end
        if (rst_v) model_edge(cyc, en, av, sy);
    endtask

    initial begin
        bit [NCH-1:0] en_v, av_v;
        int guard;
        model_reset();
        repeat (3) step('0, '0, 0, 0);

        // Single channel arriving after a delay.
        repeat (10) step(8'h01, 8'h00, 0, 1);
        repeat (200) step(8'h01, 8'h01, 0, 1);

        // All channels busy: fairness order.
        repeat (600) step(8'hFF, 8'hFF, 0, 1);

        // Sync pulse in the middle of a channel-3 burst.
        guard = 0;
        while (!(m_bstart >= 0 && m_g == 3 && cyc == m_bstart + 20) && guard < 700) begin
            step(8'hFF, 8'hFF, 0, 1); guard++;
        end
        check_val("reach_ch3", guard < 700, 1);
        step(8'hFF, 8'hFF, 1, 1);
        repeat (300) step(8'hFF, 8'hFF, ($urandom_range(0, 99) == 0), 1);

        // Masked channels with sporadic underflow on channel 2.
        repeat (500) begin
            av_v = 8'hFF;
            if ($urandom_range(0, 49) == 0) av_v[2] = 1'b0;
            step(8'h05, av_v, 0, 1);
        end

        // Fully random traffic.
        av_v = 8'(($urandom));
        en_v = 8'(($urandom));
        for (int t = 0; t < 1500; t++) begin
            if (t % 200 == 0) en_v = 8'(($urandom));
            for (int k = 0; k < NCH; k++)
                if ($urandom_range(0, 39) == 0) av_v[k] = ~av_v[k];
            step(en_v, av_v, ($urandom_range(0, 79) == 0), 1);
        end

        // Reset in the middle of a burst.
        guard = 0;
        while (!(m_bstart >= 0 && cyc == m_bstart + 30) && guard < 400) begin
            step(8'hFF, 8'hFF, 0, 1); guard++;
        end
        check_val("reach_beat30", guard < 400, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_ch_rd", ch_rd, 0);
        check_val("rst_dv", dif.dout_dv, 0);
        check_val("rst_err", err_udf, 0);
        model_reset();
        m_rst_prev = 0;
        repeat (3) step(8'hFF, 8'hFF, 0, 0);
        repeat (300) step(8'hFF, 8'hFF, 0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
